path_sequencer: RTL and testbench
=================================

// Module: path_sequencer
// PURPOSE
//  Captures the planned node path the RISC-V CPU streams out over its MMIO store port.
//  Plays the path back one node at a time to the bot navigation/motion controller.
//  Uses a valid/ready issue handshake and waits for an arrival pulse before issuing the next node.
//  Sits between the CPU data-memory write bus and the line-follower navigation block.
// PARAMETERS
//  MAX_NODES  16            path buffer depth (power of 2, >=2)
//  NODE_W     5             node-id width, taken from WriteData[NODE_W-1:0]
//  IDX_W      $clog2(MAX_NODES)+1  index/length width (holds 0..MAX_NODES)
//  PATH_ADDR  32'h02000008  MMIO address for node-append writes
//  DONE_ADDR  32'h0200000C  MMIO address for the path-complete flag (write 1)
// PORTS
//  clk         in   1       system clock, all logic posedge
//  reset_n     in   1       asynchronous, active-low reset
//  MemWrite    in   1       CPU store strobe
//  DataAdr     in   32      CPU store address
//  WriteData   in   32      CPU store data
//  abort       in   1       synchronous abort/restart request from top level
//  node_valid  out  1       node_id is presented to navigation
//  node_ready  in   1       navigation accepts node (handshake completes on valid&&ready)
//  node_id     out  NODE_W  current target node
//  node_idx    out  IDX_W   index of current target node within path
//  arrived     in   1       1-cycle pulse: bot reached the accepted node
//  path_len    out  IDX_W   number of nodes captured
//  busy        out  1       high in ISSUE or TRAVEL
//  path_done   out  1       last node reached; held until next capture or abort
//  ovf_err     out  1       sticky: append attempted while buffer full
//  seq_err     out  1       sticky: PATH_ADDR write while busy (write dropped)
// BEHAVIOUR
//  Reset: state=CAPTURE; count, rd_ptr, all outputs 0. Buffer contents don't-care.
//  MMIO writes are sampled at posedge when MemWrite=1; WriteData[31:NODE_W] is ignored.
//  DONE write qualifies only when WriteData==32'h1; other values are ignored.
//  FSM states: CAPTURE, ISSUE, TRAVEL, FINISH.
//  CAPTURE:
//   - PATH_ADDR write with count<MAX_NODES: buf[count]<=node, count++.
//   - PATH_ADDR write with count==MAX_NODES: dropped, ovf_err<=1.
//   - DONE write with count>0: rd_ptr<=0 -> ISSUE. node_valid rises the cycle after the DONE edge.
//   - DONE write with count==0: ignored, state stays CAPTURE.
//  ISSUE: node_valid=1, node_id=buf[rd_ptr], node_idx=rd_ptr.
//   - node_id is stable until the handshake completes.
//   - valid&&ready at edge -> TRAVEL; node_valid is low the next cycle.
//   - arrived in ISSUE is ignored.
//  TRAVEL: node_valid=0, node_id/node_idx hold. On arrived:
//   - rd_ptr==count-1 -> FINISH.
//   - otherwise rd_ptr++ -> ISSUE (one idle cycle between nodes).
//  FINISH: path_done=1, busy=0.
//   - PATH_ADDR write: count<=1, buf[0]<=node, path_done<=0 -> CAPTURE.
//   - DONE write: ignored.
//  PATH_ADDR write in ISSUE/TRAVEL: dropped, seq_err<=1. DONE write there: ignored.
//  abort (any state) clears count, rd_ptr, path_done, ovf_err, seq_err -> CAPTURE.
//   - abort beats a same-cycle MMIO write (write dropped).
//   - abort beats a same-cycle handshake or arrival.
//  path_len=count; busy=(ISSUE||TRAVEL). All outputs registered or decoded from registered state.
//  Async reset mid-path returns to reset state immediately; no node_valid glitch after release.
// STRUCTURE
//  path_seq_pkg: state encoding, PATH_ADDR/DONE_ADDR defaults, DONE_VALUE=32'h1.
//  Sub-module path_node_buffer: MAX_NODES x NODE_W regfile, 1 sync write port, 1 async read port.
//  Top holds the FSM, count/rd_ptr counters, sticky error flags and the MMIO decode.
// TESTING
//  1. Write nodes 3,7,12 to PATH_ADDR, then 1 to DONE_ADDR
//     -> path_len=3; node_valid next cycle with node_id=3, node_idx=0.
//  2. Same path, ready held 0 for 5 cycles -> node_id stays 3, valid high.
//     Ready=1 -> TRAVEL; arrived -> node_id=7 issued after 1 idle cycle.
//  3. Complete all 3 arrivals -> path_done=1, busy=0.
//     Then PATH_ADDR write 9 -> path_done=0, path_len=1, state CAPTURE.
//  4. 17 PATH_ADDR writes with MAX_NODES=16 -> path_len=16, ovf_err=1.
//     DONE -> node_id = 1st written node.
//  5. DONE write with count=0 and DONE write of 32'h2 -> no node_valid. PATH_ADDR write during TRAVEL -> seq_err=1, path_len unchanged.
//  6. abort coincident with a PATH_ADDR write, and reset_n low during ISSUE
//     -> count=0, all outputs 0, no stale node_valid after release.

Source files
------------

// File: rtl/path_seq_pkg.sv
// Shared constants for the path sequencer: FSM state encoding and MMIO map defaults.
package path_seq_pkg;

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_TRAVEL  = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam logic [31:0] PATH_ADDR_DEF = 32'h0200_0008;
  localparam logic [31:0] DONE_ADDR_DEF = 32'h0200_000C;
  localparam logic [31:0] DONE_VALUE    = 32'h0000_0001;

endpackage

// File: rtl/path_sequencer_if.sv
// CPU store bus plus the node issue/arrival link to navigation. master = CPU/navigation side,
// slave = the path sequencer.
interface path_sequencer_if #(
  parameter int NODE_W = 5,
  parameter int IDX_W  = 5
);

  logic              MemWrite;
  logic [31:0]       DataAdr;
  logic [31:0]       WriteData;
  logic              node_valid;
  logic              node_ready;
  logic [NODE_W-1:0] node_id;
  logic [IDX_W-1:0]  node_idx;
  logic              arrived;

  modport master (
    output MemWrite, DataAdr, WriteData, node_ready, arrived,
    input  node_valid, node_id, node_idx
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, node_ready, arrived,
    output node_valid, node_id, node_idx
  );

endinterface

// File: rtl/path_node_buffer.sv
// Path storage: MAX_NODES x NODE_W register file, one synchronous write port, one async read port.
module path_node_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are meaningless until written, so no reset is applied.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/path_sequencer.sv
// Captures a node path from CPU MMIO stores and replays it to navigation one node at a time,
// waiting for an arrival pulse before issuing the next node.
module path_sequencer
  import path_seq_pkg::*;
#(
  parameter int          MAX_NODES = 16,
  parameter int          NODE_W    = 5,
  parameter int          IDX_W     = $clog2(MAX_NODES) + 1,
  parameter logic [31:0] PATH_ADDR = PATH_ADDR_DEF,
  parameter logic [31:0] DONE_ADDR = DONE_ADDR_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  path_sequencer_if.slave  bus,
  output logic [IDX_W-1:0] path_len,
  output logic             busy,
  output logic             path_done,
  output logic             ovf_err,
  output logic             seq_err,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(MAX_NODES);

  logic [1:0]        state;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  rd_ptr;
  logic [NODE_W-1:0] rd_node;
  logic [NODE_W-1:0] wr_node;
  logic [AW-1:0]     buf_waddr;
  logic              path_wr;
  logic              done_wr;
  logic              full;
  logic              buf_we;

  assign path_wr   = bus.MemWrite && (bus.DataAdr == PATH_ADDR);
  assign done_wr   = bus.MemWrite && (bus.DataAdr == DONE_ADDR) && (bus.WriteData == DONE_VALUE);
  assign wr_node   = bus.WriteData[NODE_W-1:0];
  assign full      = (count == IDX_W'(MAX_NODES));
  // A write from FINISH starts a fresh path at slot 0.
  assign buf_we    = !abort && path_wr &&
                     (((state == ST_CAPTURE) && !full) || (state == ST_FINISH));
  assign buf_waddr = (state == ST_FINISH) ? '0 : count[AW-1:0];

  path_node_buffer #(
    .DEPTH (MAX_NODES),
    .W     (NODE_W),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (wr_node),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_node)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CAPTURE;
      count     <= '0;
      rd_ptr    <= '0;
      path_done <= 1'b0;
      ovf_err   <= 1'b0;
      seq_err   <= 1'b0;
    end else if (abort) begin
      state     <= ST_CAPTURE;
      count     <= '0;
      rd_ptr    <= '0;
      path_done <= 1'b0;
      ovf_err   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (path_wr) begin
            if (full) ovf_err <= 1'b1;
            else      count   <= count + IDX_W'(1);
          end else if (done_wr && (count != '0)) begin
            rd_ptr <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (path_wr) seq_err <= 1'b1;
          if (bus.node_ready) state <= ST_TRAVEL;
        end
        ST_TRAVEL: begin
          if (path_wr) seq_err <= 1'b1;
          if (bus.arrived) begin
            if (rd_ptr == count - IDX_W'(1)) begin
              path_done <= 1'b1;
              state     <= ST_FINISH;
            end else begin
              rd_ptr <= rd_ptr + IDX_W'(1);
              state  <= ST_ISSUE;
            end
          end
        end
        default: begin
          if (path_wr) begin
            count     <= IDX_W'(1);
            path_done <= 1'b0;
            state     <= ST_CAPTURE;
          end
        end
      endcase
    end
  end

  // Issue handshake: node_valid stays high with node_id/node_idx stable until an edge where
  // node_ready is also high; that edge hands the node over. node_ready without node_valid is ignored.
  assign busy           = (state == ST_ISSUE) || (state == ST_TRAVEL);
  assign bus.node_valid = (state == ST_ISSUE);
  assign bus.node_id    = busy ? rd_node : '0;
  assign bus.node_idx   = busy ? rd_ptr  : '0;
  assign path_len       = count;
  assign state_dbg      = state;

endmodule

// File: tb/tb_path_sequencer.sv
// Directed bench for path_sequencer: path-level reference model checked every cycle,
// plus hand-computed checkpoints for each scenario.
module tb_path_sequencer;

  localparam int          MAX_NODES = 16;
  localparam int          NODE_W    = 5;
  localparam int          IDX_W     = 5;
  localparam logic [31:0] PATH_A    = 32'h0200_0008;
  localparam logic [31:0] DONE_A    = 32'h0200_000C;

  logic             clk;
  logic             reset_n;
  logic             abort;
  logic [IDX_W-1:0] path_len;
  logic             busy;
  logic             path_done;
  logic             ovf_err;
  logic             seq_err;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  path_sequencer_if #(.NODE_W(NODE_W), .IDX_W(IDX_W)) bus ();

  path_sequencer #(
    .MAX_NODES (MAX_NODES),
    .NODE_W    (NODE_W),
    .IDX_W     (IDX_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .abort     (abort),
    .bus       (bus),
    .path_len  (path_len),
    .busy      (busy),
    .path_done (path_done),
    .ovf_err   (ovf_err),
    .seq_err   (seq_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The path is a queue of node ids; playback is tracked as "playing", "offered vs en route"
  // and "finished", with a cursor into the queue.
  logic [NODE_W-1:0] exp_q[$];
  int m_cur    = 0;
  bit m_run    = 0;
  bit m_offer  = 0;
  bit m_done   = 0;
  bit m_ovf    = 0;
  bit m_seq    = 0;

  task automatic model_clear();
    exp_q.delete();
    m_cur = 0; m_run = 0; m_offer = 0; m_done = 0; m_ovf = 0; m_seq = 0;
  endtask

  initial begin
    bit pw;
    bit dw;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        pw = bus.MemWrite && (bus.DataAdr == PATH_A);
        dw = bus.MemWrite && (bus.DataAdr == DONE_A) && (bus.WriteData == 32'h1);
        if (abort) begin
          model_clear();
        end else if (m_done) begin
          if (pw) begin
            exp_q.delete();
            exp_q.push_back(bus.WriteData[NODE_W-1:0]);
            m_done = 0;
          end
        end else if (!m_run) begin
          if (pw) begin
            if (exp_q.size() < MAX_NODES) exp_q.push_back(bus.WriteData[NODE_W-1:0]);
            else m_ovf = 1;
          end else if (dw && exp_q.size() > 0) begin
            m_run = 1; m_offer = 1; m_cur = 0;
          end
        end else begin
          if (pw) m_seq = 1;
          if (m_offer) begin
            if (bus.node_ready) m_offer = 0;
          end else if (bus.arrived) begin
            if (m_cur == exp_q.size() - 1) begin
              m_run = 0; m_done = 1;
            end else begin
              m_cur++; m_offer = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_node_valid", 32'(bus.node_valid), 32'(m_run && m_offer));
        check("cyc_busy",       32'(busy),           32'(m_run));
        check("cyc_node_id",    32'(bus.node_id),    m_run ? 32'(exp_q[m_cur]) : 32'h0);
        check("cyc_node_idx",   32'(bus.node_idx),   m_run ? 32'(m_cur) : 32'h0);
        check("cyc_path_len",   32'(path_len),       32'(exp_q.size()));
        check("cyc_path_done",  32'(path_done),      32'(m_done));
        check("cyc_ovf_err",    32'(ovf_err),        32'(m_ovf));
        check("cyc_seq_err",    32'(seq_err),        32'(m_seq));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.DataAdr = a; bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
  endtask

  task automatic handshake();
    @(negedge clk); bus.node_ready = 1'b1;
    @(negedge clk); bus.node_ready = 1'b0;
  endtask

  task automatic arrive();
    @(negedge clk); bus.arrived = 1'b1;
    @(negedge clk); bus.arrived = 1'b0;
  endtask

  task automatic abort_pulse();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset_n = 1'b0; abort = 1'b0;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    bus.node_ready = 1'b0; bus.arrived = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.node_valid), 32'h0);
    check("rst_len",   32'(path_len),       32'h0);
    check("rst_state", 32'(state_dbg),      32'h0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Capture 3,7,12 and start playback.
    mmio_write(PATH_A, 32'd3);
    mmio_write(PATH_A, 32'd7);
    mmio_write(PATH_A, 32'd12);
    mmio_write(DONE_A, 32'h1);
    check("t1_len",   32'(path_len),       32'd3);
    check("t1_valid", 32'(bus.node_valid), 32'h1);
    check("t1_id",    32'(bus.node_id),    32'd3);
    check("t1_idx",   32'(bus.node_idx),   32'd0);

    // Stall on ready, then hand over and travel.
    repeat (5) @(negedge clk);
    check("t2_stall_valid", 32'(bus.node_valid), 32'h1);
    check("t2_stall_id",    32'(bus.node_id),    32'd3);
    handshake();
    check("t2_travel_valid", 32'(bus.node_valid), 32'h0);
    check("t2_travel_id",    32'(bus.node_id),    32'd3);
    arrive();
    check("t2_next_valid", 32'(bus.node_valid), 32'h1);
    check("t2_next_id",    32'(bus.node_id),    32'd7);
    check("t2_next_idx",   32'(bus.node_idx),   32'd1);

    // Finish the path, then restart capture from FINISH.
    handshake(); arrive();
    check("t3_id12", 32'(bus.node_id), 32'd12);
    handshake(); arrive();
    check("t3_done", 32'(path_done), 32'h1);
    check("t3_busy", 32'(busy),      32'h0);
    mmio_write(DONE_A, 32'h1);
    check("t3_done_ignored", 32'(path_done), 32'h1);
    mmio_write(PATH_A, 32'd9);
    check("t3_done_clr", 32'(path_done), 32'h0);
    check("t3_len1",     32'(path_len),  32'd1);
    check("t3_capture",  32'(state_dbg), 32'h0);

    // Overflow: 17 appends into a 16-deep buffer.
    abort_pulse();
    check("t4_abort_len", 32'(path_len), 32'd0);
    for (int i = 0; i < 17; i++) mmio_write(PATH_A, 32'(i + 2));
    check("t4_len", 32'(path_len), 32'd16);
    check("t4_ovf", 32'(ovf_err),  32'h1);
    mmio_write(DONE_A, 32'h1);
    check("t4_first_id", 32'(bus.node_id),    32'd2);
    check("t4_valid",    32'(bus.node_valid), 32'h1);
    abort_pulse();

    // DONE qualification, upper data bits ignored, ISSUE ignores arrival, writes while busy.
    mmio_write(DONE_A, 32'h1);
    check("t5_empty_done", 32'(bus.node_valid), 32'h0);
    mmio_write(PATH_A, 32'hFFFF_FFE4);
    mmio_write(DONE_A, 32'h2);
    check("t5_done2_valid", 32'(bus.node_valid), 32'h0);
    check("t5_done2_state", 32'(state_dbg),      32'h0);
    mmio_write(PATH_A, 32'd5);
    mmio_write(DONE_A, 32'h1);
    check("t5_masked_id", 32'(bus.node_id), 32'd4);
    arrive();
    check("t5_arr_in_issue", 32'(bus.node_valid), 32'h1);
    handshake();
    mmio_write(PATH_A, 32'd6);
    check("t5_seq_err", 32'(seq_err),  32'h1);
    check("t5_len",     32'(path_len), 32'd2);
    mmio_write(DONE_A, 32'h1);
    check("t5_travel_done", 32'(bus.node_valid), 32'h0);

    // Abort beats a same-cycle append and a same-cycle handshake.
    abort_pulse();
    mmio_write(PATH_A, 32'd1);
    @(negedge clk);
    abort = 1'b1; bus.MemWrite = 1'b1; bus.DataAdr = PATH_A; bus.WriteData = 32'd2;
    @(negedge clk);
    abort = 1'b0; bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    check("t6_abort_wr_len", 32'(path_len), 32'd0);
    mmio_write(PATH_A, 32'd8);
    mmio_write(DONE_A, 32'h1);
    @(negedge clk);
    abort = 1'b1; bus.node_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.node_ready = 1'b0;
    check("t6_abort_hs_valid", 32'(bus.node_valid), 32'h0);
    check("t6_abort_hs_busy",  32'(busy),           32'h0);

    // Asynchronous reset while a node is being offered.
    mmio_write(PATH_A, 32'd6);
    mmio_write(DONE_A, 32'h1);
    check("t6_pre_rst_id", 32'(bus.node_id), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.node_valid), 32'h0);
    check("t6_rst_len",   32'(path_len),       32'h0);
    check("t6_rst_id",    32'(bus.node_id),    32'h0);
    check("t6_rst_busy",  32'(busy),           32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_valid", 32'(bus.node_valid), 32'h0);
    check("t6_post_state", 32'(state_dbg),      32'h0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
